// File: rtl/iec_sd_arbiter.sv
// ---------------------------------------------------------------------------
// iec_sd_arbiter
//
// Multi-drive SD request arbiter and mux for the IEC drive subsystem. Up to
// NDR drive cores (1541/1571/1581/DNP) each present an SD block request
// channel; this block picks one at a time with a round-robin grant, latches
// its direction and translated LBA/count, runs the request/ack handshake
// with the single host SD block interface, and aborts a request the host
// never acknowledges.
//
// Parameters
//   NDR      number of drive channels (1..8)
//   LBA_W    LBA width
//   CNT_W    block-count width (count minus one)
//   TIMEOUT  strobe cycles to wait for sd_ack before abort; 0 = never abort
//
// Ports
//   clk_sys       in   system clock, rising edge
//   reset         in   synchronous active-high reset
//   drv_type      in   4*NDR      per-drive type code, 4'b1111 = unconnected
//   drv_rd        in   NDR        per-drive read request (level)
//   drv_wr        in   NDR        per-drive write request (level)
//   drv_lba       in   LBA_W*NDR  per-drive LBA
//   drv_blk_cnt   in   CNT_W*NDR  per-drive block count minus one
//   drv_buff_din  in   8*NDR      per-drive write data
//   drv_ack       out  NDR        per-drive ack (sd_ack routed to the grantee)
//   sd_lba        out  LBA_W      host LBA
//   sd_blk_cnt    out  CNT_W      host block count
//   sd_rd         out  1          host read strobe (level)
//   sd_wr         out  1          host write strobe (level)
//   sd_ack        in   1          host ack
//   sd_buff_din   out  8          host write data from the granted drive
//   busy          out  1          transaction in progress
//   grant         out  3          granted drive index, valid while busy
//   timeout_err   out  NDR        one-cycle pulse on an aborted drive's bit
// ---------------------------------------------------------------------------
module iec_sd_arbiter #(
  parameter int          NDR     = 4,
  parameter int          LBA_W   = 32,
  parameter int          CNT_W   = 6,
  parameter logic [23:0] TIMEOUT = 24'd12000000
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic [4*NDR-1:0]       drv_type,
  input  logic [NDR-1:0]         drv_rd,
  input  logic [NDR-1:0]         drv_wr,
  input  logic [LBA_W*NDR-1:0]   drv_lba,
  input  logic [CNT_W*NDR-1:0]   drv_blk_cnt,
  input  logic [8*NDR-1:0]       drv_buff_din,
  output logic [NDR-1:0]         drv_ack,
  output logic [LBA_W-1:0]       sd_lba,
  output logic [CNT_W-1:0]       sd_blk_cnt,
  output logic                   sd_rd,
  output logic                   sd_wr,
  input  logic                   sd_ack,
  output logic [7:0]             sd_buff_din,
  output logic                   busy,
  output logic [2:0]             grant,
  output logic [NDR-1:0]         timeout_err
);

  // A single-drive build still needs a one-bit index register.
  localparam int IDX_W = (NDR > 1) ? $clog2(NDR) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_XFER    = 2'd2,
    S_RELEASE = 2'd3
  } state_e;

  // 1581 images address 256-byte sectors in 512-byte SD blocks two at a
  // time, so the drive's LBA is doubled and the transfer is a fixed pair.
  function automatic logic [LBA_W-1:0] xlat_lba(input logic [1:0]       t,
                                                input logic [LBA_W-1:0] l);
    if (t == 2'b10) return l << 1;
    return l;
  endfunction

  function automatic logic [CNT_W-1:0] xlat_cnt(input logic [1:0]       t,
                                                input logic [CNT_W-1:0] c);
    if (t == 2'b10) return CNT_W'(1);
    return c;
  endfunction

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic               dir_wr_q, dir_wr_d;
  logic [LBA_W-1:0]   lba_q, lba_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [23:0]        tmo_q, tmo_d;
  logic               rd_q, rd_d;
  logic               wr_q, wr_d;
  logic [NDR-1:0]     terr_q, terr_d;

  logic [NDR-1:0]     req;
  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic               grant_req;
  logic               strobe_q;

  // Only connected drives take part in arbitration.
  always_comb begin
    for (int i = 0; i < NDR; i++) begin
      req[i] = (drv_rd[i] | drv_wr[i]) && (drv_type[4*i +: 4] != 4'b1111);
    end
  end

  // Round-robin search starting one past the last served drive. The last
  // candidate visited is the pointer itself, so a drive that keeps its
  // request up is served again only after every other requester.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = 1; k <= NDR; k++) begin
      if (!hit && req[(int'(ptr_q) + k) % NDR]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'((int'(ptr_q) + k) % NDR);
      end
    end
  end

  // The grantee's raw request; the type is not re-checked so a type change
  // mid-transaction cannot cancel it.
  assign grant_req = drv_rd[grant_q] | drv_wr[grant_q];
  assign strobe_q  = rd_q | wr_q;

  // Next-state logic. The strobe is registered one cycle behind ISSUE entry,
  // so the host sees the latched LBA/count a cycle before the strobe and the
  // request-to-strobe latency is two cycles. The timeout counter only runs
  // while the strobe is actually presented to the host.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    dir_wr_d = dir_wr_q;
    lba_d    = lba_q;
    cnt_d    = cnt_q;
    tmo_d    = '0;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    terr_d   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (hit) begin
          grant_d  = hit_idx;
          // Read wins when both levels are up.
          dir_wr_d = drv_wr[hit_idx] & ~drv_rd[hit_idx];
          lba_d    = xlat_lba(drv_type[4*int'(hit_idx) +: 2],
                              drv_lba[LBA_W*int'(hit_idx) +: LBA_W]);
          cnt_d    = xlat_cnt(drv_type[4*int'(hit_idx) +: 2],
                              drv_blk_cnt[CNT_W*int'(hit_idx) +: CNT_W]);
          state_d  = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (sd_ack) begin
          state_d = S_XFER;
        end else if (!grant_req) begin
          ptr_d   = grant_q;
          state_d = S_IDLE;
        end else if ((TIMEOUT != 24'd0) && strobe_q &&
                     (tmo_q == TIMEOUT - 24'd1)) begin
          terr_d[grant_q] = 1'b1;
          ptr_d           = grant_q;
          state_d         = S_IDLE;
        end else begin
          tmo_d = strobe_q ? tmo_q + 24'd1 : tmo_q;
          rd_d  = ~dir_wr_q;
          wr_d  = dir_wr_q;
        end
      end

      S_XFER: begin
        if (!sd_ack) begin
          ptr_d   = grant_q;
          state_d = S_RELEASE;
        end
      end

      S_RELEASE: begin
        // One quiet cycle so the drive observes its ack low before any
        // re-grant can happen.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      dir_wr_q <= 1'b0;
      lba_q    <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      terr_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      dir_wr_q <= dir_wr_d;
      lba_q    <= lba_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      terr_q   <= terr_d;
    end
  end

  // Host ack is routed straight through to the grantee while the handshake
  // is open; other drives never see it.
  always_comb begin
    drv_ack = '0;
    if ((state_q == S_ISSUE) || (state_q == S_XFER)) begin
      drv_ack[grant_q] = sd_ack;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign sd_buff_din = busy ? drv_buff_din[8*int'(grant_q) +: 8] : 8'd0;
  assign grant       = 3'(grant_q);
  assign sd_rd       = rd_q;
  assign sd_wr       = wr_q;
  assign sd_lba      = lba_q;
  assign sd_blk_cnt  = cnt_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_iec_sd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_iec_sd_arbiter
//
// Directed scenarios followed by randomized transactions for iec_sd_arbiter
// (NDR=4, TIMEOUT=16). Expected grants, directions and translated fields
// come from a transaction-level model: a round-robin pointer plus plain
// arithmetic on the drive inputs.
// ---------------------------------------------------------------------------
module tb_iec_sd_arbiter;

  localparam int NDR   = 4;
  localparam int LBA_W = 32;
  localparam int CNT_W = 6;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [4*NDR-1:0]     drv_type;
  logic [NDR-1:0]       drv_rd;
  logic [NDR-1:0]       drv_wr;
  logic [LBA_W*NDR-1:0] drv_lba;
  logic [CNT_W*NDR-1:0] drv_blk_cnt;
  logic [8*NDR-1:0]     drv_buff_din;
  logic [NDR-1:0]       drv_ack;
  logic [LBA_W-1:0]     sd_lba;
  logic [CNT_W-1:0]     sd_blk_cnt;
  logic                 sd_rd;
  logic                 sd_wr;
  logic                 sd_ack;
  logic [7:0]           sd_buff_din;
  logic                 busy;
  logic [2:0]           grant;
  logic [NDR-1:0]       timeout_err;

  int checks   = 0;
  int failures = 0;
  int ptr_m    = 0;   // model round-robin pointer
  int obs_g    = -1;  // grant seen in the last transaction

  always #5 clk = ~clk;

  iec_sd_arbiter #(
    .NDR(NDR), .LBA_W(LBA_W), .CNT_W(CNT_W), .TIMEOUT(24'd16)
  ) dut (
    .clk_sys(clk), .reset(reset),
    .drv_type(drv_type), .drv_rd(drv_rd), .drv_wr(drv_wr),
    .drv_lba(drv_lba), .drv_blk_cnt(drv_blk_cnt),
    .drv_buff_din(drv_buff_din), .drv_ack(drv_ack),
    .sd_lba(sd_lba), .sd_blk_cnt(sd_blk_cnt),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_din(sd_buff_din), .busy(busy), .grant(grant),
    .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---- reference model --------------------------------------------------
  function automatic bit connected_req(input int i);
    return (drv_rd[i] || drv_wr[i]) && (drv_type[i*4 +: 4] != 4'hF);
  endfunction

  function automatic int rr_pick(input int ptr);
    for (int k = 1; k <= NDR; k++) begin
      if (connected_req((ptr + k) % NDR)) return (ptr + k) % NDR;
    end
    return -1;
  endfunction

  function automatic logic [31:0] exp_lba(input int g);
    longint v;
    v = longint'(drv_lba[g*32 +: 32]);
    if (drv_type[g*4 +: 4] % 4 == 2) v = (v * 2) % 64'h1_0000_0000;
    return 32'(v);
  endfunction

  function automatic logic [5:0] exp_cnt(input int g);
    if (drv_type[g*4 +: 4] % 4 == 2) return 6'd1;
    return drv_blk_cnt[g*6 +: 6];
  endfunction

  function automatic logic [7:0] din_of(input int g);
    return drv_buff_din[g*8 +: 8];
  endfunction

  task automatic clear_drives();
    drv_type     = '0;
    drv_rd       = '0;
    drv_wr       = '0;
    drv_lba      = '0;
    drv_blk_cnt  = '0;
    drv_buff_din = '0;
    sd_ack       = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ack"},  64'(drv_ack), 64'(0));
    chk({tag, "_lba"},  64'(sd_lba), 64'(0));
    chk({tag, "_cnt"},  64'(sd_blk_cnt), 64'(0));
    chk({tag, "_strb"}, 64'({sd_rd, sd_wr}), 64'(0));
    chk({tag, "_din"},  64'(sd_buff_din), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_gnt"},  64'(grant), 64'(0));
    chk({tag, "_terr"}, 64'(timeout_err), 64'(0));
  endtask

  task automatic do_reset();
    clear_drives();
    reset = 1'b1;
    tick();
    tick();
    check_all_zero("rst");
    reset = 1'b0;
    ptr_m = 0;
  endtask

  // One transaction from an IDLE cycle whose inputs are already applied.
  // mode 0: host acks after adly strobe cycles, xlen XFER cycles
  // mode 1: grantee drops its request while the strobe is up
  // mode 2: host never acks -> abort after 16 strobe cycles
  // Returns with the arbiter back in IDLE, one cycle after an edge.
  task automatic run_txn(input int mode, input int adly, input int xlen,
                         input bit hold);
    int          g;
    bit          wr;
    logic [31:0] el;
    logic [5:0]  ec;
    logic [3:0]  oh;
    g = rr_pick(ptr_m);
    if (g < 0) begin
      obs_g = -1;
      tick();
      chk("idle_busy", 64'(busy), 64'(0));
      tick();
      chk("idle_strb", 64'({sd_rd, sd_wr}), 64'(0));
      return;
    end
    wr = !drv_rd[g];
    el = exp_lba(g);
    ec = exp_cnt(g);
    oh = 4'b0001 << g;

    tick();  // grant registered, strobe not yet up
    obs_g = int'(grant);
    chk("gnt_busy", 64'(busy), 64'(1));
    chk("gnt_idx",  64'(grant), 64'(g));
    chk("gnt_strb", 64'({sd_rd, sd_wr}), 64'(0));
    chk("gnt_terr", 64'(timeout_err), 64'(0));

    tick();  // strobe up, two cycles after the request
    chk("iss_rd",  64'(sd_rd), 64'(!wr));
    chk("iss_wr",  64'(sd_wr), 64'(wr));
    chk("iss_lba", 64'(sd_lba), 64'(el));
    chk("iss_cnt", 64'(sd_blk_cnt), 64'(ec));
    // latched translation must survive a type change
    drv_type[g*4 +: 4] = 4'($urandom_range(0, 14));
    drv_buff_din       = $urandom;
    #1;
    chk("iss_din", 64'(sd_buff_din), 64'(din_of(g)));

    case (mode)
      0: begin
        repeat (adly) begin
          tick();
          chk("wait_strb", 64'({sd_rd, sd_wr}), 64'({!wr, wr}));
          chk("wait_ack",  64'(drv_ack), 64'(0));
        end
        sd_ack = 1'b1;
        #1;
        chk("ack_route", 64'(drv_ack), 64'(oh));
        tick();  // XFER
        chk("xfer_strb", 64'({sd_rd, sd_wr}), 64'(0));
        chk("xfer_busy", 64'(busy), 64'(1));
        for (int c = 0; c < xlen; c++) begin
          drv_buff_din = $urandom;
          #1;
          chk("xfer_din", 64'(sd_buff_din), 64'(din_of(g)));
          chk("xfer_ack", 64'(drv_ack), 64'(oh));
          tick();
        end
        chk("xfer_lba", 64'(sd_lba), 64'(el));
        chk("xfer_cnt", 64'(sd_blk_cnt), 64'(ec));
        sd_ack = 1'b0;
        if (!hold) begin
          drv_rd[g] = 1'b0;
          drv_wr[g] = 1'b0;
        end
        #1;
        chk("ackfall", 64'(drv_ack), 64'(0));
        tick();  // RELEASE
        chk("rel_busy", 64'(busy), 64'(1));
        chk("rel_strb", 64'({sd_rd, sd_wr}), 64'(0));
        tick();  // IDLE
        chk("end_busy", 64'(busy), 64'(0));
        chk("end_din",  64'(sd_buff_din), 64'(0));
        ptr_m = g;
      end
      1: begin
        drv_rd[g] = 1'b0;
        drv_wr[g] = 1'b0;
        #1;
        chk("drop_ack", 64'(drv_ack), 64'(0));
        tick();
        chk("drop_strb", 64'({sd_rd, sd_wr}), 64'(0));
        chk("drop_busy", 64'(busy), 64'(0));
        chk("drop_terr", 64'(timeout_err), 64'(0));
        ptr_m = g;
      end
      default: begin
        for (int c = 1; c < 16; c++) begin
          tick();
          chk("tmo_strb", 64'({sd_rd, sd_wr}), 64'({!wr, wr}));
          chk("tmo_terr0", 64'(timeout_err), 64'(0));
        end
        tick();
        chk("tmo_drop", 64'({sd_rd, sd_wr}), 64'(0));
        chk("tmo_busy", 64'(busy), 64'(0));
        chk("tmo_pulse", 64'(timeout_err), 64'(oh));
        ptr_m = g;
      end
    endcase
  endtask

  logic [3:0] type_tbl [7];
  int         prev_g;

  initial begin
    type_tbl = '{4'h0, 4'h1, 4'h2, 4'h6, 4'hA, 4'hE, 4'hF};
    reset    = 1'b1;
    clear_drives();

    // reset state
    do_reset();

    // single read, pass-through translation
    drv_rd[0]          = 1'b1;
    drv_lba[0 +: 32]   = 32'd357;
    drv_blk_cnt[0 +: 6] = 6'd0;
    run_txn(0, 2, 2, 1'b0);
    chk("t1_grant", 64'(obs_g), 64'(0));
    chk("t1_lba",   64'(sd_lba), 64'(357));
    chk("t1_cnt",   64'(sd_blk_cnt), 64'(0));

    // 1581 write: LBA doubled and truncated, count forced to one
    clear_drives();
    drv_wr[2]              = 1'b1;
    drv_type[8 +: 4]       = 4'b1010;
    drv_lba[64 +: 32]      = 32'h8000_0001;
    drv_blk_cnt[12 +: 6]   = 6'd5;
    run_txn(0, 0, 3, 1'b0);
    chk("t2_grant", 64'(obs_g), 64'(2));
    chk("t2_lba",   64'(sd_lba), 64'(32'h0000_0002));
    chk("t2_cnt",   64'(sd_blk_cnt), 64'(1));

    // fairness from pointer 0 with held requests; unconnected drive ignored
    do_reset();
    drv_rd           = 4'b1111;
    drv_type[8 +: 4] = 4'hF;
    for (int k = 0; k < 4; k++) begin
      run_txn(0, 1, 1, 1'b1);
      case (k)
        0: chk("t3_order0", 64'(obs_g), 64'(1));
        1: chk("t3_order1", 64'(obs_g), 64'(3));
        2: chk("t3_order2", 64'(obs_g), 64'(0));
        default: chk("t3_order3", 64'(obs_g), 64'(1));
      endcase
    end

    // timeout abort, then the other requester is served
    drv_rd = 4'b1010;
    run_txn(2, 0, 0, 1'b1);
    chk("t4_tmo_grant", 64'(obs_g), 64'(3));
    prev_g = obs_g;
    run_txn(0, 0, 1, 1'b0);
    chk("t4_next_grant", 64'(obs_g), 64'(1));
    chk("t4_differs", 64'(obs_g != prev_g), 64'(1));

    // request withdrawn during ISSUE
    clear_drives();
    drv_rd[1] = 1'b1;
    run_txn(1, 0, 0, 1'b0);
    chk("t5_grant", 64'(obs_g), 64'(1));

    // reset in XFER with sd_ack high
    clear_drives();
    drv_rd[3] = 1'b1;
    tick();
    tick();
    sd_ack = 1'b1;
    tick();
    chk("t6_xfer_ack", 64'(drv_ack), 64'(4'b1000));
    reset = 1'b1;
    tick();
    check_all_zero("t6");
    reset  = 1'b0;
    sd_ack = 1'b0;
    ptr_m  = 0;
    drv_rd = 4'b0110;
    run_txn(0, 0, 0, 1'b0);
    chk("t6_after_rst", 64'(obs_g), 64'(1));

    // randomized transactions
    for (int it = 0; it < 60; it++) begin
      for (int i = 0; i < NDR; i++) begin
        drv_type[i*4 +: 4]  = type_tbl[$urandom_range(0, 6)];
        drv_rd[i]           = 1'($urandom_range(0, 1));
        drv_wr[i]           = 1'($urandom_range(0, 1));
        drv_lba[i*32 +: 32] = $urandom;
        drv_blk_cnt[i*6 +: 6] = 6'($urandom_range(0, 63));
      end
      drv_buff_din = $urandom;
      case ($urandom_range(0, 5))
        4:       run_txn(1, 0, 0, 1'b0);
        5:       run_txn(2, 0, 0, 1'b0);
        default: run_txn(0, int'($urandom_range(0, 7)),
                         int'($urandom_range(0, 3)),
                         1'($urandom_range(0, 1)));
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
